// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 message padder: message bytes, 0x80, zero fill, 64-bit big-endian bit length.
// Optional macro SHA_PAD_OVF_CHECK_EN builds the sticky byte-counter overflow flag.
module sha256_msg_padder #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       empty,
    input  logic [7:0] msg_data,
    input  logic       msg_valid,
    input  logic       msg_last,
    output logic       msg_ready,
    output logic       out_start,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       len_ovf
);

    typedef enum logic [2:0] {IDLE, MSG, PAD80, ZERO, LEN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [5:0]         pos;
    logic [63:0]        len_sh;
    logic               first;

    logic               xfer;
    logic [5:0]         pos_nxt;
    logic [63:0]        len_val;

    assign pos_nxt = pos + 6'd1;
    assign len_val = {61'(cnt), 3'b000};
    assign busy    = (state != IDLE);

    // MSG is a zero-latency pass-through, so the output mux is combinational.
    always_comb begin
        msg_ready = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        out_last  = 1'b0;
        case (state)
            MSG: begin
                msg_ready = out_ready;
                out_valid = msg_valid;
                out_data  = msg_data;
            end
            PAD80: begin
                out_valid = 1'b1;
                out_data  = 8'h80;
            end
            ZERO: begin
                out_valid = 1'b1;
            end
            LEN: begin
                out_valid = 1'b1;
                out_data  = len_sh[63:56];
                out_last  = (pos == 6'd63);
            end
            default: ;
        endcase
    end

    assign xfer      = out_valid & out_ready;
    assign out_start = first & out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            pos    <= '0;
            len_sh <= '0;
            first  <= 1'b0;
        end else begin
            if (xfer)
                first <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        pos   <= '0;
                        first <= 1'b1;
                        state <= empty ? PAD80 : MSG;
                    end
                end
                MSG: begin
                    if (xfer) begin
                        cnt <= cnt + CNT_W'(1);
                        pos <= pos_nxt;
                        if (msg_last)
                            state <= PAD80;
                    end
                end
                PAD80, ZERO: begin
                    if (xfer) begin
                        pos <= pos_nxt;
                        if (pos_nxt == 6'd56) begin
                            len_sh <= len_val;
                            state  <= LEN;
                        end else begin
                            state  <= ZERO;
                        end
                    end
                end
                LEN: begin
                    if (xfer) begin
                        pos    <= pos_nxt;
                        len_sh <= {len_sh[55:0], 8'h00};
                        if (pos == 6'd63)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHA_PAD_OVF_CHECK_EN
    logic ovf;

    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (state == IDLE && start)
            ovf <= 1'b0;
        else if (state == MSG && xfer && (&cnt))
            ovf <= 1'b1;
    end

    assign len_ovf = ovf;
`else
    assign len_ovf = 1'b0;
`endif

endmodule
